// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Shared constants for the sequential ALU. Holds the 3-bit
//                opcode map {L,M,N} and the controller state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

   // Opcode map. It matches the earlier combinational 4-bit ALU, with MUL
   // and MOD now working.
   localparam logic [2:0] OP_NEG_A = 3'b000;
   localparam logic [2:0] OP_NEG_B = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;
   localparam logic [2:0] OP_MOD   = 3'b111;

   // Controller states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : seq_muldiv
//  Description : Iterative unit performing a WIDTH-step unsigned shift-add
//                multiply or restoring divide. Both operations share one
//                step counter and one 2*WIDTH accumulator.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                start        - load operands and begin (ignored-free pulse)
//                is_mod       - 1: divide (A mod B / A div B), 0: multiply
//                a, b         - operands, sampled on start
//                busy         - an operation is in progress
//                done         - all WIDTH steps finished; lo/hi are valid
//                lo, hi       - MUL: product low/high; MOD: remainder/quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_mod,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int               CNT_W   = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_STEPS = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;     // multiplicand (MUL) or divisor (MOD)
   logic               r_isMod;
   logic               r_busy;
   logic [CNT_W-1:0]   r_count;

   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [WIDTH:0]     w_divCand;
   logic [WIDTH:0]     w_divDiff;
   logic [2*WIDTH-1:0] w_divNext;

   // Multiply: the multiplier sits in the low half and is consumed LSB
   // first; the partial product grows in the high half. The sum keeps its
   // carry bit, which becomes the new MSB after the right shift.
   always_comb begin
      w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
      w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};
   end

   // Restoring divide: the dividend is shifted out of the low half into the
   // partial remainder; quotient bits are shifted into the vacated LSBs.
   // The candidate remainder needs WIDTH+1 bits since it may reach 2*B-1.
   always_comb begin
      w_divCand = r_acc[2*WIDTH-1:WIDTH-1];
      w_divDiff = w_divCand - {1'b0, r_opnd};
      if (!w_divDiff[WIDTH]) begin
         w_divNext = {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_divNext = {w_divCand[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc   <= '0;
         r_opnd  <= '0;
         r_isMod <= 1'b0;
         r_busy  <= 1'b0;
         r_count <= '0;
      end else if (start) begin
         r_acc   <= {{WIDTH{1'b0}}, (is_mod ? a : b)};
         r_opnd  <= is_mod ? b : a;
         r_isMod <= is_mod;
         r_busy  <= 1'b1;
         r_count <= C_STEPS;
      end else if (r_busy) begin
         if (r_count != '0) begin
            r_acc   <= r_isMod ? w_divNext : w_mulNext;
            r_count <= r_count - 1'b1;
         end else begin
            // Result was presented via done this cycle; release the unit.
            r_busy <= 1'b0;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_busy && (r_count == '0);
   assign lo   = r_isMod ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
   assign hi   = r_isMod ? r_acc[WIDTH-1:0]       : r_acc[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU with valid/ready operand and result
//                handshakes. NEG/ADD/SUB/AND/OR complete at the accept edge;
//                MUL and MOD run WIDTH steps in seq_muldiv.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                in_valid/in_ready     - operand handshake (op, a, b)
//                out_valid/out_ready   - result handshake
//                result, result_hi     - primary result / MUL high, MOD quot.
//                carry, overflow, zero, div_zero - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             div_zero
);

   import seq_alu_pkg::*;

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;

   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_resultHi;
   logic             r_carry;
   logic             r_overflow;
   logic             r_zero;
   logic             r_divZero;
   logic             r_isMod;

   logic             w_inReady;
   logic             w_accept;
   logic             w_startIter;
   logic             w_mdBusy;
   logic             w_mdDone;
   logic             w_iterFinish;
   logic [WIDTH-1:0] w_mdLo;
   logic [WIDTH-1:0] w_mdHi;

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_addOv;

   logic [WIDTH-1:0] w_singleResult;
   logic [WIDTH-1:0] w_singleHi;
   logic             w_singleCarry;
   logic             w_singleOv;
   logic             w_singleDz;

   assign w_accept     = in_valid && w_inReady;
   // A modulo by zero bypasses the iterative unit and finishes in one cycle.
   assign w_startIter  = w_accept && ((op == OP_MUL) || ((op == OP_MOD) && (b != '0)));
   assign w_iterFinish = w_mdBusy && w_mdDone;

   // ---------------------------------------------------------------------
   // Single-cycle datapath: every arithmetic op is x + y + cin.
   // ---------------------------------------------------------------------
   always_comb begin
      w_x   = a;
      w_y   = b;
      w_cin = 1'b0;
      case (op)
         OP_NEG_A: begin w_x = ~a; w_y = '0; w_cin = 1'b1; end
         OP_NEG_B: begin w_x = ~b; w_y = '0; w_cin = 1'b1; end
         OP_SUB:   begin w_x = a;  w_y = ~b; w_cin = 1'b1; end
         default:  begin w_x = a;  w_y = b;  w_cin = 1'b0; end
      endcase
      w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
      w_addOv = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
   end

   always_comb begin
      w_singleResult = '0;
      w_singleHi     = '0;
      w_singleCarry  = 1'b0;
      w_singleOv     = 1'b0;
      w_singleDz     = 1'b0;
      case (op)
         OP_NEG_A, OP_NEG_B, OP_ADD, OP_SUB: begin
            w_singleResult = w_sum[WIDTH-1:0];
            w_singleCarry  = w_sum[WIDTH];
            w_singleOv     = w_addOv;
         end
         OP_AND: w_singleResult = a & b;
         OP_OR:  w_singleResult = a | b;
         OP_MOD: begin
            // Only reached with b == 0
            w_singleResult = a;
            w_singleHi     = '1;
            w_singleDz     = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Controller: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_nextState = w_startIter ? S_BUSY : S_DONE;
         S_BUSY:  if (w_iterFinish) w_nextState = S_DONE;
         S_DONE:  if (out_ready) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_inReady = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
   end

   assign in_ready = w_inReady;

   // ---------------------------------------------------------------------
   // Result registers: loaded at the accept edge for single-cycle ops, or
   // at the edge following the last iterative step.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result   <= '0;
         r_resultHi <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
         r_divZero  <= 1'b0;
         r_isMod    <= 1'b0;
      end else if (r_state == S_IDLE && w_accept) begin
         r_isMod <= (op == OP_MOD);
         if (!w_startIter) begin
            r_result   <= w_singleResult;
            r_resultHi <= w_singleHi;
            r_carry    <= w_singleCarry;
            r_overflow <= w_singleOv;
            r_zero     <= (w_singleResult == '0);
            r_divZero  <= w_singleDz;
         end
      end else if (r_state == S_BUSY && w_iterFinish) begin
         r_result   <= w_mdLo;
         r_resultHi <= w_mdHi;
         r_carry    <= 1'b0;
         r_overflow <= r_isMod ? 1'b0 : (w_mdHi != '0);
         r_zero     <= (w_mdLo == '0);
         r_divZero  <= 1'b0;
      end
   end

   assign result    = r_result;
   assign result_hi = r_resultHi;
   assign carry     = r_carry;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
   assign div_zero  = r_divZero;

   seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (w_startIter),
      .is_mod (op == OP_MOD),
      .a      (a),
      .b      (b),
      .busy   (w_mdBusy),
      .done   (w_mdDone),
      .lo     (w_mdLo),
      .hi     (w_mdHi)
   );

endmodule
`default_nettype wire
